// File: rtl/regfetch_fwd.sv
// Register fetch stage for a dual-issue pipe: 128x128 register file with two write ports,
// six-operand forwarding resolution and a registered operand/control output stage.
module regfetch_fwd #(
    parameter int unsigned CTRL_W = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  stall_i,
    input  logic                  flush_i,

    input  logic                  ev_valid_i,
    input  logic                  od_valid_i,
    input  logic [6:0]            ev_ra_addr_i,
    input  logic [6:0]            ev_rb_addr_i,
    input  logic [6:0]            ev_rc_addr_i,
    input  logic [6:0]            od_ra_addr_i,
    input  logic [6:0]            od_rb_addr_i,
    input  logic [6:0]            od_rt_addr_i,
    input  logic [CTRL_W-1:0]     ev_ctrl_i,
    input  logic [CTRL_W-1:0]     od_ctrl_i,

    input  logic [127:0]          ev_rt_wb_i,
    input  logic [127:0]          od_rt_wb_i,
    input  logic [6:0]            ev_rt_addr_wb_i,
    input  logic [6:0]            od_rt_addr_wb_i,
    input  logic                  ev_reg_write_wb_i,
    input  logic                  od_reg_write_wb_i,

    input  logic [6:0][127:0]     ev_fw_wb_i,
    input  logic [6:0][127:0]     od_fw_wb_i,
    input  logic [6:0][6:0]       ev_fw_addr_wb_i,
    input  logic [6:0][6:0]       od_fw_addr_wb_i,
    input  logic [6:0]            ev_fw_write_wb_i,
    input  logic [6:0]            od_fw_write_wb_i,

    output logic [127:0]          ev_ra_o,
    output logic [127:0]          ev_rb_o,
    output logic [127:0]          ev_rc_o,
    output logic [127:0]          od_ra_o,
    output logic [127:0]          od_rb_o,
    output logic [127:0]          od_rt_st_o,
    output logic                  ev_valid_q_o,
    output logic                  od_valid_q_o,
    output logic [CTRL_W-1:0]     ev_ctrl_q_o,
    output logic [CTRL_W-1:0]     od_ctrl_q_o
);

    localparam int unsigned NumSrc = 6;
    localparam int unsigned NumReg = 128;
    localparam int unsigned FwDepth = 6;

    logic [127:0]      rf_q [NumReg];
    logic [6:0]        src_addr [NumSrc];
    logic [127:0]      src_val [NumSrc];

    logic [127:0]      op_q [NumSrc];
    logic [127:0]      op_d [NumSrc];
    logic              ev_valid_q, ev_valid_d;
    logic              od_valid_q, od_valid_d;
    logic [CTRL_W-1:0] ev_ctrl_q, ev_ctrl_d;
    logic [CTRL_W-1:0] od_ctrl_q, od_ctrl_d;

    // Staging slot 0 is architecturally unused; fold it away so it never matches.
    logic unused_fw0;
    assign unused_fw0 = ^{ev_fw_wb_i[0], od_fw_wb_i[0], ev_fw_addr_wb_i[0],
                          od_fw_addr_wb_i[0], ev_fw_write_wb_i[0], od_fw_write_wb_i[0]};

    // Odd port is written last so it wins an address collision.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NumReg; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            if (ev_reg_write_wb_i) begin
                rf_q[ev_rt_addr_wb_i] <= ev_rt_wb_i;
            end
            if (od_reg_write_wb_i) begin
                rf_q[od_rt_addr_wb_i] <= od_rt_wb_i;
            end
        end
    end

    assign src_addr[0] = ev_ra_addr_i;
    assign src_addr[1] = ev_rb_addr_i;
    assign src_addr[2] = ev_rc_addr_i;
    assign src_addr[3] = od_ra_addr_i;
    assign src_addr[4] = od_rb_addr_i;
    assign src_addr[5] = od_rt_addr_i;

    // Sources are layered oldest-first so the last matching assignment is the youngest;
    // within one depth the odd pipe is applied after the even pipe.
    always_comb begin
        for (int g = 0; g < NumSrc; g++) begin
            src_val[g] = rf_q[src_addr[g]];
            if (ev_reg_write_wb_i && (ev_rt_addr_wb_i == src_addr[g])) begin
                src_val[g] = ev_rt_wb_i;
            end
            if (od_reg_write_wb_i && (od_rt_addr_wb_i == src_addr[g])) begin
                src_val[g] = od_rt_wb_i;
            end
            for (int d = FwDepth; d >= 1; d--) begin
                if (ev_fw_write_wb_i[d] && (ev_fw_addr_wb_i[d] == src_addr[g])) begin
                    src_val[g] = ev_fw_wb_i[d];
                end
                if (od_fw_write_wb_i[d] && (od_fw_addr_wb_i[d] == src_addr[g])) begin
                    src_val[g] = od_fw_wb_i[d];
                end
            end
        end
    end

    always_comb begin
        for (int g = 0; g < NumSrc; g++) begin
            op_d[g] = op_q[g];
        end
        ev_valid_d = ev_valid_q;
        od_valid_d = od_valid_q;
        ev_ctrl_d  = ev_ctrl_q;
        od_ctrl_d  = od_ctrl_q;

        if (flush_i) begin
            // Operands are don't-care on a kill; loading them keeps the mux simple.
            for (int g = 0; g < NumSrc; g++) begin
                op_d[g] = src_val[g];
            end
            ev_valid_d = 1'b0;
            od_valid_d = 1'b0;
            ev_ctrl_d  = '0;
            od_ctrl_d  = '0;
        end else if (!stall_i) begin
            for (int g = 0; g < NumSrc; g++) begin
                op_d[g] = src_val[g];
            end
            ev_valid_d = ev_valid_i;
            od_valid_d = od_valid_i;
            ev_ctrl_d  = ev_ctrl_i;
            od_ctrl_d  = od_ctrl_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int g = 0; g < NumSrc; g++) begin
                op_q[g] <= '0;
            end
            ev_valid_q <= 1'b0;
            od_valid_q <= 1'b0;
            ev_ctrl_q  <= '0;
            od_ctrl_q  <= '0;
        end else begin
            for (int g = 0; g < NumSrc; g++) begin
                op_q[g] <= op_d[g];
            end
            ev_valid_q <= ev_valid_d;
            od_valid_q <= od_valid_d;
            ev_ctrl_q  <= ev_ctrl_d;
            od_ctrl_q  <= od_ctrl_d;
        end
    end

    assign ev_ra_o      = op_q[0];
    assign ev_rb_o      = op_q[1];
    assign ev_rc_o      = op_q[2];
    assign od_ra_o      = op_q[3];
    assign od_rb_o      = op_q[4];
    assign od_rt_st_o   = op_q[5];
    assign ev_valid_q_o = ev_valid_q;
    assign od_valid_q_o = od_valid_q;
    assign ev_ctrl_q_o  = ev_ctrl_q;
    assign od_ctrl_q_o  = od_ctrl_q;

endmodule

// File: doc/regfetch_fwd.md
REGFETCH_FWD -- requirements
Module: regfetch_fwd

Interface
REQ-001 Parameter: CTRL_W, 32, width of the opaque decoded-control bundle per lane, passed through unmodified.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 stall  in  1  hold all output registers this cycle.
REQ-005 flush  in  1  kill the instruction pair being latched (branch_kill / branch_taken).
REQ-006 ev_valid, od_valid  in  1 each  even/odd lane instruction present.
REQ-007 ev_ra_addr, ev_rb_addr, ev_rc_addr  in  7 each  even-lane source register addresses.
REQ-008 od_ra_addr, od_rb_addr, od_rt_addr  in  7 each  odd-lane sources; od_rt_addr is read as store data.
REQ-009 ev_ctrl, od_ctrl  in  CTRL_W each  decoded op/format/unit/rt_addr/imm/pc bundle.
REQ-010 ev_rt_wb, od_rt_wb  in  128 each  writeback data from the even/odd pipe.
REQ-011 ev_rt_addr_wb, od_rt_addr_wb  in  7 each; ev_reg_write_wb, od_reg_write_wb  in  1 each  writeback address/enable.
REQ-012 ev_fw_wb, od_fw_wb  in  7x128 each; ev_fw_addr_wb, od_fw_addr_wb  in  7x7 each; ev_fw_write_wb, od_fw_write_wb  in  7 each  forwarding staging entries, index 1 youngest, index 6 oldest, index 0 unused.
REQ-013 ev_ra, ev_rb, ev_rc  out  128 each  registered even-lane operands.
REQ-014 od_ra, od_rb, od_rt_st  out  128 each  registered odd-lane operands.
REQ-015 ev_valid_q, od_valid_q  out  1 each; ev_ctrl_q, od_ctrl_q  out  CTRL_W each  registered lane valid/control.

Function
REQ-016 The block SHALL hold a 128-entry x 128-bit register file; every entry, including entry 0, is writable.
REQ-017 On posedge clk, when ev_reg_write_wb=1 the block SHALL write ev_rt_wb to entry ev_rt_addr_wb; likewise for the odd port.
REQ-018 When both write ports target the same address in one cycle, the odd port's value SHALL be stored.
REQ-019 Each of the six operands SHALL be resolved combinationally, first match wins: fw entries 1..6 in ascending order, then the wb ports, then the register file.
REQ-020 A fw entry or wb port SHALL match only when its write flag is 1 and its address equals the source address.
REQ-021 At equal depth, including the two wb ports, an odd-pipe match SHALL take precedence over an even-pipe match, consistent with REQ-018.
REQ-022 Fw entry 0 SHALL never match, regardless of its inputs.
REQ-023 Latency SHALL be one cycle: the operands resolved in cycle N appear on the outputs after posedge N+1.
REQ-024 Register-file writes SHALL complete independent of stall and flush.
REQ-025 When stall=1 and flush=0, all output registers SHALL hold their values.
REQ-026 When flush=1, ev_valid_q and od_valid_q SHALL load 0 and the ctrl_q outputs SHALL load 0, whatever the value of stall.
REQ-027 Operand outputs are don't-care when flush=1.
REQ-028 Otherwise the outputs SHALL load the resolved operands, ev_valid/od_valid and ev_ctrl/od_ctrl.
REQ-029 Operands SHALL be resolved and latched even when the lane valid is 0; the value is don't-care.

Reset
REQ-030 While reset=1 at posedge clk, all register-file entries and all outputs SHALL load 0.
REQ-031 While reset=1, writes SHALL be suppressed and reset SHALL take precedence over stall and flush.
REQ-032 On the first posedge after reset deasserts, the block SHALL operate normally; no warm-up cycles.

Verification
REQ-033 Write/read: wb odd r5=0xA5..A5, next cycle od_ra_addr=5, no fw hits -> od_ra=0xA5..A5 one cycle later.
REQ-034 Priority: RF r9=1, od fw[6] r9=2, ev fw[3] r9=3, od fw[3] r9=4 -> operand=4; drop od fw[3] -> 3; drop both fw[3] -> 2.
REQ-035 Same-cycle bypass: od wb r12=0x77 while od_rb_addr=12 -> od_rb=0x77, RF r12=0x77 after the edge.
REQ-036 Collision: ev and od wb both to r3 (0x11, 0x22) -> RF r3=0x22.
REQ-037 Stall/flush: stall=1 for 3 cycles holds outputs; flush=1 with stall=1 -> valid_q=0, ctrl_q=0; a wb issued during stall still updates the RF.
REQ-038 Reset mid-operation: reset=1 with wb active -> RF entry stays 0, all outputs 0, valid_q=0.
